multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/mc_pkg.sv | 63 ++++++
 rtl/multicycle_control_if.sv | 25 ++
 rtl/mc_wait_timer.sv | 35 +++
 rtl/multicycle_control_fsm.sv | 176 +++++++++++++++++
 rtl/multicycle_control.sv | 62 ++++++
 tb/tb_multicycle_control.sv | 264 ++++++++++++++++++++++++++
 6 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller: state codes, opcodes,
// ALU/mux select encodings and the control-word payload.
package mc_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned OP_W    = 6;

    localparam logic [STATE_W-1:0] S_IDLE     = 4'd0;
    localparam logic [STATE_W-1:0] S_FETCH    = 4'd1;
    localparam logic [STATE_W-1:0] S_DECODE   = 4'd2;
    localparam logic [STATE_W-1:0] S_MEM_ADDR = 4'd3;
    localparam logic [STATE_W-1:0] S_MEM_RD   = 4'd4;
    localparam logic [STATE_W-1:0] S_MEM_WB   = 4'd5;
    localparam logic [STATE_W-1:0] S_MEM_WR   = 4'd6;
    localparam logic [STATE_W-1:0] S_EXEC_R   = 4'd7;
    localparam logic [STATE_W-1:0] S_R_WB     = 4'd8;
    localparam logic [STATE_W-1:0] S_BRANCH   = 4'd9;
    localparam logic [STATE_W-1:0] S_JUMP     = 4'd10;
    localparam logic [STATE_W-1:0] S_ADDI_EX  = 4'd11;
    localparam logic [STATE_W-1:0] S_ADDI_WB  = 4'd12;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_e;

    typedef enum logic [1:0] {
        SRCB_RT     = 2'b00,
        SRCB_FOUR   = 2'b01,
        SRCB_IMM    = 2'b10,
        SRCB_IMM_SH = 2'b11
    } alu_src_b_e;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10
    } pc_source_e;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        alu_src_b_e alu_src_b;
        alu_op_e    alu_op;
        pc_source_e pc_source;
    } mc_ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Controller bus: datapath status in (master drives), control word and status out.
interface multicycle_control_if;
    import mc_pkg::*;

    logic                start;
    logic [OP_W-1:0]     op;
    logic                zero;
    logic                mem_ready;
    mc_ctrl_t            ctrl;
    logic                instr_done;
    logic                illegal;
    logic                mem_err;
    logic [STATE_W-1:0]  state;

    modport master (
        output start, op, zero, mem_ready,
        input  ctrl, instr_done, illegal, mem_err, state
    );

    modport slave (
        input  start, op, zero, mem_ready,
        output ctrl, instr_done, illegal, mem_err, state
    );

endinterface

// File: rtl/mc_wait_timer.sv
// Memory wait-cycle counter; expired_c flags the last allowed wait cycle.
module mc_wait_timer #(
    parameter int unsigned WAIT_LIMIT = 15
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_c
);

    localparam int unsigned CNT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expired_c = (cnt_q == CNT_W'(WAIT_LIMIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_c) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS-subset control FSM. Memory handshake/timeout only when
// MC_MEM_WAIT_EN is defined; otherwise each memory state takes one cycle.
module multicycle_control_fsm
    import mc_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 15
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    multicycle_control_if.slave  bus
);

    logic [STATE_W-1:0] state_q, state_d;
    logic [STATE_W-1:0] after_done_c;
    mc_ctrl_t           ctrl_c;
    logic               done_c;
    logic               illegal_c;
    logic               mem_err_c;
    logic               mem_go_c;
    logic               mem_abort_c;

`ifdef MC_MEM_WAIT_EN
    logic wait_state_c;
    logic expired_c;

    assign wait_state_c = (state_q == S_FETCH) || (state_q == S_MEM_RD) ||
                          (state_q == S_MEM_WR);

    // Any state change restarts the count, so each waiting state starts at zero.
    mc_wait_timer #(
        .WAIT_LIMIT (WAIT_LIMIT)
    ) u_wait_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (state_d != state_q),
        .en_i      (wait_state_c && !bus.mem_ready),
        .expired_c (expired_c)
    );

    assign mem_go_c    = bus.mem_ready;
    assign mem_abort_c = !bus.mem_ready && expired_c;
`else
    logic unused_mem_ready;

    assign unused_mem_ready = ^{bus.mem_ready, 32'(WAIT_LIMIT)};
    assign mem_go_c         = 1'b1;
    assign mem_abort_c      = 1'b0;
`endif

    assign after_done_c = bus.start ? S_FETCH : S_IDLE;

    // Next state and Moore control word; only BRANCH pc_write follows zero.
    always_comb begin
        state_d   = state_q;
        ctrl_c    = '0;
        done_c    = 1'b0;
        illegal_c = 1'b0;
        mem_err_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_FETCH;
            end
            S_FETCH: begin
                ctrl_c.mem_read  = 1'b1;
                ctrl_c.alu_src_b = SRCB_FOUR;
                if (mem_go_c) begin
                    ctrl_c.ir_write = 1'b1;
                    ctrl_c.pc_write = 1'b1;
                    state_d         = S_DECODE;
                end else if (mem_abort_c) begin
                    mem_err_c = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_DECODE: begin
                ctrl_c.alu_src_b = SRCB_IMM_SH;
                case (bus.op)
                    OP_RTYPE:     state_d = S_EXEC_R;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    default: begin
                        illegal_c = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = SRCB_IMM;
                state_d          = (bus.op == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                ctrl_c.mem_read = 1'b1;
                ctrl_c.i_or_d   = 1'b1;
                if (mem_go_c) begin
                    state_d = S_MEM_WB;
                end else if (mem_abort_c) begin
                    mem_err_c = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_MEM_WB: begin
                ctrl_c.mem_to_reg = 1'b1;
                ctrl_c.reg_write  = 1'b1;
                done_c            = 1'b1;
                state_d           = after_done_c;
            end
            S_MEM_WR: begin
                ctrl_c.mem_write = 1'b1;
                ctrl_c.i_or_d    = 1'b1;
                if (mem_go_c) begin
                    done_c  = 1'b1;
                    state_d = after_done_c;
                end else if (mem_abort_c) begin
                    mem_err_c = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_EXEC_R: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_op    = ALUOP_FUNCT;
                state_d          = S_R_WB;
            end
            S_R_WB: begin
                ctrl_c.reg_dst   = 1'b1;
                ctrl_c.reg_write = 1'b1;
                done_c           = 1'b1;
                state_d          = after_done_c;
            end
            S_BRANCH: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_op    = ALUOP_SUB;
                ctrl_c.pc_source = PCSRC_ALUOUT;
                ctrl_c.pc_write  = bus.zero;
                done_c           = 1'b1;
                state_d          = after_done_c;
            end
            S_JUMP: begin
                ctrl_c.pc_write  = 1'b1;
                ctrl_c.pc_source = PCSRC_JUMP;
                done_c           = 1'b1;
                state_d          = after_done_c;
            end
            S_ADDI_EX: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = SRCB_IMM;
                state_d          = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                ctrl_c.reg_write = 1'b1;
                done_c           = 1'b1;
                state_d          = after_done_c;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign bus.ctrl       = ctrl_c;
    assign bus.instr_done = done_c;
    assign bus.illegal    = illegal_c;
    assign bus.mem_err    = mem_err_c;
    assign bus.state      = state_q;

endmodule

// File: rtl/multicycle_control.sv
// Multicycle controller top: flat port wrapper around the FSM.
// Optional memory wait/timeout handling enabled by defining MC_MEM_WAIT_EN.
module multicycle_control #(
    parameter int unsigned WAIT_LIMIT = 15
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [5:0] op_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       pc_write_o,
    output logic       ir_write_o,
    output logic       i_or_d_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       mem_to_reg_o,
    output logic       reg_dst_o,
    output logic       reg_write_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] alu_op_o,
    output logic [1:0] pc_source_o,
    output logic       instr_done_o,
    output logic       illegal_o,
    output logic       mem_err_o,
    output logic [3:0] state_o
);

    multicycle_control_if bus ();

    assign bus.start     = start_i;
    assign bus.op        = op_i;
    assign bus.zero      = zero_i;
    assign bus.mem_ready = mem_ready_i;

    multicycle_control_fsm #(
        .WAIT_LIMIT (WAIT_LIMIT)
    ) u_fsm (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    assign pc_write_o   = bus.ctrl.pc_write;
    assign ir_write_o   = bus.ctrl.ir_write;
    assign i_or_d_o     = bus.ctrl.i_or_d;
    assign mem_read_o   = bus.ctrl.mem_read;
    assign mem_write_o  = bus.ctrl.mem_write;
    assign mem_to_reg_o = bus.ctrl.mem_to_reg;
    assign reg_dst_o    = bus.ctrl.reg_dst;
    assign reg_write_o  = bus.ctrl.reg_write;
    assign alu_src_a_o  = bus.ctrl.alu_src_a;
    assign alu_src_b_o  = bus.ctrl.alu_src_b;
    assign alu_op_o     = bus.ctrl.alu_op;
    assign pc_source_o  = bus.ctrl.pc_source;
    assign instr_done_o = bus.instr_done;
    assign illegal_o    = bus.illegal;
    assign mem_err_o    = bus.mem_err;
    assign state_o      = bus.state;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: the driver pushes one expected
// output vector per cycle, the monitor pops and compares on the falling edge.
module tb_multicycle_control;
    import mc_pkg::*;

    localparam int unsigned WAIT_LIMIT = 15;
`ifdef MC_MEM_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg;
    logic       reg_dst, reg_write, alu_src_a, instr_done, illegal, mem_err;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;
    logic [21:0] act_v;

    multicycle_control_if bus ();

    multicycle_control #(.WAIT_LIMIT(WAIT_LIMIT)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(bus.start), .op_i(bus.op),
        .zero_i(bus.zero), .mem_ready_i(bus.mem_ready),
        .pc_write_o(pc_write), .ir_write_o(ir_write), .i_or_d_o(i_or_d),
        .mem_read_o(mem_read), .mem_write_o(mem_write), .mem_to_reg_o(mem_to_reg),
        .reg_dst_o(reg_dst), .reg_write_o(reg_write), .alu_src_a_o(alu_src_a),
        .alu_src_b_o(alu_src_b), .alu_op_o(alu_op), .pc_source_o(pc_source),
        .instr_done_o(instr_done), .illegal_o(illegal), .mem_err_o(mem_err),
        .state_o(state)
    );

    assign act_v = {state, pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg,
                    reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
                    instr_done, illegal, mem_err};

    logic [21:0] exp_q[$];
    string       name_q[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc_n = 0;
    bit          at_fetch;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected outputs of one cycle, straight from the per-state output table.
    function automatic logic [21:0] model_vec(input logic [3:0] st, input logic z,
                                              input logic rdy, input logic done,
                                              input logic ill, input logic err);
        logic pcw, irw, iod, mr, mw, m2r, rd, rw, asa;
        logic [1:0] bsb, aop, psrc;
        {pcw, irw, iod, mr, mw, m2r, rd, rw, asa} = '0;
        bsb = 2'b00; aop = 2'b00; psrc = 2'b00;
        if (st == S_FETCH)    begin mr = 1'b1; bsb = 2'b01; irw = rdy; pcw = rdy; end
        if (st == S_DECODE)   bsb = 2'b11;
        if (st == S_MEM_ADDR || st == S_ADDI_EX) begin asa = 1'b1; bsb = 2'b10; end
        if (st == S_MEM_RD)   begin mr = 1'b1; iod = 1'b1; end
        if (st == S_MEM_WB)   begin m2r = 1'b1; rw = 1'b1; end
        if (st == S_MEM_WR)   begin mw = 1'b1; iod = 1'b1; end
        if (st == S_EXEC_R)   begin asa = 1'b1; aop = 2'b10; end
        if (st == S_R_WB)     begin rd = 1'b1; rw = 1'b1; end
        if (st == S_BRANCH)   begin asa = 1'b1; aop = 2'b01; psrc = 2'b01; pcw = z; end
        if (st == S_JUMP)     begin pcw = 1'b1; psrc = 2'b10; end
        if (st == S_ADDI_WB)  rw = 1'b1;
        return {st, pcw, irw, iod, mr, mw, m2r, rd, rw, asa, bsb, aop, psrc, done, ill, err};
    endfunction

    task automatic push(input logic [3:0] st, input logic rdy, input logic done,
                        input logic ill, input logic err, input string nm);
        exp_q.push_back(model_vec(st, bus.zero, rdy, done, ill, err));
        name_q.push_back(nm);
    endtask

    task automatic cyc(input logic [3:0] st, input logic rdy, input logic done,
                       input logic ill, input logic err, input string nm);
        push(st, rdy, done, ill, err, nm);
        @(posedge clk);
        #1;
    endtask

    task automatic mid(input logic [3:0] st, input string nm);
        bus.start = 1'($urandom);
        cyc(st, 1'b1, 1'b0, 1'b0, 1'b0, nm);
    endtask

    task automatic fin(input logic [3:0] st, input bit keep, input string nm);
        bus.start = keep;
        cyc(st, 1'b1, 1'b1, 1'b0, 1'b0, nm);
    endtask

    // A memory state: optional not-ready cycles, then the completing cycle.
    task automatic mem_phase(input logic [3:0] st, input int waits, input bit is_final,
                             input bit keep, input string nm);
        int w;
        w = 0;
        if (WAIT_EN) w = (waits < 0) ? int'($urandom_range(0, 3)) : waits;
        for (int i = 0; i < w; i++) begin
            bus.mem_ready = 1'b0;
            bus.start     = 1'($urandom);
            cyc(st, 1'b0, 1'b0, 1'b0, 1'b0, nm);
        end
        bus.mem_ready = WAIT_EN ? 1'b1 : 1'($urandom);
        bus.start     = is_final ? keep : 1'($urandom);
        cyc(st, 1'b1, is_final, 1'b0, 1'b0, nm);
    endtask

    task automatic idle(input int n);
        bus.start = 1'b0;
        for (int i = 0; i < n; i++) cyc(S_IDLE, 1'b1, 1'b0, 1'b0, 1'b0, "idle");
        bus.start = 1'b1;
        cyc(S_IDLE, 1'b1, 1'b0, 1'b0, 1'b0, "idle_go");
    endtask

    task automatic do_instr(input logic [5:0] op, input logic z, input bit keep,
                            input int fw, input int dw, output bit next_fetch);
        bus.op     = op;
        bus.zero   = z;
        next_fetch = keep;
        mem_phase(S_FETCH, fw, 1'b0, 1'b0, "fetch");
        case (op)
            6'b000000: begin mid(S_DECODE, "r_dec"); mid(S_EXEC_R, "r_exec"); fin(S_R_WB, keep, "r_wb"); end
            6'b100011: begin
                mid(S_DECODE, "lw_dec"); mid(S_MEM_ADDR, "lw_addr");
                mem_phase(S_MEM_RD, dw, 1'b0, 1'b0, "lw_rd"); fin(S_MEM_WB, keep, "lw_wb");
            end
            6'b101011: begin
                mid(S_DECODE, "sw_dec"); mid(S_MEM_ADDR, "sw_addr");
                mem_phase(S_MEM_WR, dw, 1'b1, keep, "sw_wr");
            end
            6'b000100: begin mid(S_DECODE, "beq_dec"); fin(S_BRANCH, keep, "beq_br"); end
            6'b000010: begin mid(S_DECODE, "j_dec"); fin(S_JUMP, keep, "j_jump"); end
            6'b001000: begin mid(S_DECODE, "addi_dec"); mid(S_ADDI_EX, "addi_ex"); fin(S_ADDI_WB, keep, "addi_wb"); end
            default: begin
                bus.start = 1'($urandom);
                cyc(S_DECODE, 1'b1, 1'b0, 1'b1, 1'b0, "illegal_dec");
                next_fetch = 1'b1;
            end
        endcase
    endtask

`ifdef MC_MEM_WAIT_EN
    task automatic timeout_in(input logic [3:0] st, input string nm);
        for (int i = 1; i <= int'(WAIT_LIMIT); i++) begin
            bus.mem_ready = 1'b0;
            bus.start     = 1'($urandom);
            cyc(st, 1'b0, 1'b0, 1'b0, 1'(i == int'(WAIT_LIMIT)), nm);
        end
    endtask
`endif

    function automatic logic [5:0] pick_op();
        logic [5:0] ops[8];
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                6'b000010, 6'b001000, 6'b111111, 6'b010001};
        return ops[$urandom_range(0, 7)];
    endfunction

    // Monitor: one expected vector per cycle, sampled mid-cycle.
    initial begin
        logic [21:0] e;
        string       nm;
        forever begin
            @(negedge clk);
            cyc_n++;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                total++;
                if (act_v !== e) begin
                    bad++;
                    $display("FAIL %s cycle %0d: got %h want %h", nm, cyc_n, act_v, e);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Driver: directed scenarios first, then a random instruction stream.
    initial begin
        bit nf;
        int k;
        rst = 1'b1;
        bus.start = 1'b1; bus.op = 6'b0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        cyc(S_IDLE, 1'b1, 1'b0, 1'b0, 1'b0, "reset");
        rst = 1'b0;
        bus.start = 1'b0;
        cyc(S_IDLE, 1'b1, 1'b0, 1'b0, 1'b0, "post_reset");
        bus.start = 1'b1;
        cyc(S_IDLE, 1'b1, 1'b0, 1'b0, 1'b0, "start");

        do_instr(6'b000000, 1'b0, 1'b1, 0, 0, nf);
        do_instr(6'b000100, 1'b1, 1'b1, 0, 0, nf);
        do_instr(6'b000100, 1'b0, 1'b1, 0, 0, nf);
        do_instr(6'b111111, 1'b0, 1'b1, 0, 0, nf);
        do_instr(6'b100011, 1'b0, 1'b1, 0, 3, nf);
`ifdef MC_MEM_WAIT_EN
        timeout_in(S_FETCH, "fetch_timeout");
        idle(1);
        bus.op = 6'b100011;
        mem_phase(S_FETCH, 0, 1'b0, 1'b0, "fetch");
        mid(S_DECODE, "lw_dec");
        mid(S_MEM_ADDR, "lw_addr");
        timeout_in(S_MEM_RD, "rd_timeout");
        idle(0);
`endif

        // Asynchronous reset while in MEM_WR.
        bus.op = 6'b101011;
        mem_phase(S_FETCH, 0, 1'b0, 1'b0, "fetch");
        mid(S_DECODE, "sw_dec");
        mid(S_MEM_ADDR, "sw_addr");
        bus.mem_ready = 1'b0;
        bus.start     = 1'b1;
        push(S_MEM_WR, !WAIT_EN, !WAIT_EN, 1'b0, 1'b0, "sw_wr_pre_reset");
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (act_v !== model_vec(S_IDLE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0)) begin
            bad++;
            $display("FAIL async_reset: got %h want %h", act_v,
                     model_vec(S_IDLE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        end
        @(posedge clk);
        #1;
        cyc(S_IDLE, 1'b1, 1'b0, 1'b0, 1'b0, "reset_held");
        rst = 1'b0;
        bus.start = 1'b1;
        cyc(S_IDLE, 1'b1, 1'b0, 1'b0, 1'b0, "reset_release");

        at_fetch = 1'b1;
        for (int n = 0; n < 250; n++) begin
            if (!at_fetch) idle(int'($urandom_range(0, 3)));
            do_instr(pick_op(), 1'($urandom), ($urandom_range(0, 3) != 0), -1, -1, nf);
            at_fetch = nf;
        end

        k = 0;
        while (exp_q.size() != 0 && k < 10) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
